// File: rtl/br_ctrl_pkg.sv
// Shared types and constants for the branch/trap redirect controller.
package br_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'b00,
        PC_REDIRECT = 2'b01,
        PC_HOLD     = 2'b10
    } pc_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_t;

endpackage

// File: rtl/redirect_perf_cnt.sv
// Wrapping 32-bit event counter for redirect statistics; built only when
// BRANCH_REDIRECT_PERF_EN is defined.
module redirect_perf_cnt
    import br_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    output logic [XLEN-1:0] cnt_o
);

    logic [XLEN-1:0] cnt_q;

    // Natural modular wrap from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (inc_i)
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC redirect / flush / stall controller for taken branches and CSR traps.
// Optional performance counters are enabled with BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl
    import br_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            csr_redirect,
    input  logic [XLEN-1:0] csr_target,
    input  logic            load_use,
    input  logic            imem_ready,
    output logic [1:0]      pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            stall_if,
    output logic            stall_id,
    output logic            busy
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [XLEN-1:0] br_redirect_cnt,
    output logic [XLEN-1:0] csr_redirect_cnt
`endif
);

    redir_state_t    state_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            capture;

    assign capture = (state_q == IDLE) && (csr_redirect || (ex_valid && br_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q       <= REDIRECT;
                        redirect_pc_q <= csr_redirect ? csr_target : br_target;
                    end
                end
                REDIRECT: begin
                    // A late trap retargets fetch and costs one more redirect cycle
                    // even if the old target was accepted this cycle.
                    if (csr_redirect)
                        redirect_pc_q <= csr_target;
                    else if (imem_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_sel      = PC_PLUS4;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        if (!rst) begin
            if (state_q == REDIRECT) begin
                pc_sel      = PC_REDIRECT;
                flush_if_id = 1'b1;
            end else if (capture) begin
                pc_sel      = PC_HOLD;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                pc_sel      = PC_HOLD;
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign busy        = (state_q == REDIRECT);

`ifdef BRANCH_REDIRECT_PERF_EN
    logic br_inc;
    logic csr_inc;

    // CSR requests always win: capture in IDLE, override in REDIRECT.
    assign br_inc  = capture && !csr_redirect;
    assign csr_inc = csr_redirect;

    redirect_perf_cnt u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (br_inc),
        .cnt_o (br_redirect_cnt)
    );

    redirect_perf_cnt u_csr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (csr_inc),
        .cnt_o (csr_redirect_cnt)
    );
`endif

endmodule
